// File: rtl/mult_control.sv
// Sequencing FSM for the signed add-shift multiplier: CLR, then N_BITS add/shift pairs, last add subtracts.
// Optional Busy/Done status outputs are built when MULT_CTRL_STATUS_EN is defined.
module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_A,
  output logic Clr_X,
  output logic Ld_B,
  output logic Ld_A,
  output logic Ld_X,
  output logic Shift_En,
  output logic Fn
`ifdef MULT_CTRL_STATUS_EN
  ,
  output logic Busy,
  output logic Done
`endif
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  // Run has priority over ClearA_LoadB in IDLE; a held Run parks the FSM in DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) r_state <= S_CLR;
        end
        S_CLR: begin
          r_cnt   <= '0;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          if (!Run) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode: M only matters in ADD, and the last ADD subtracts for sign correction.
  always_comb begin
    Clr_A    = 1'b0;
    Clr_X    = 1'b0;
    Ld_B     = 1'b0;
    Ld_A     = 1'b0;
    Ld_X     = 1'b0;
    Shift_En = 1'b0;
    Fn       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Run && ClearA_LoadB) begin
          Clr_A = 1'b1;
          Clr_X = 1'b1;
          Ld_B  = 1'b1;
        end
      end
      S_CLR: begin
        Clr_A = 1'b1;
        Clr_X = 1'b1;
      end
      S_ADD: begin
        Ld_A = M;
        Ld_X = M;
        Fn   = w_last;
      end
      S_SHIFT: begin
        Shift_En = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef MULT_CTRL_STATUS_EN
  assign Busy = (r_state == S_CLR) || (r_state == S_ADD) || (r_state == S_SHIFT);
  assign Done = (r_state == S_DONE);
`endif

endmodule
